// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshakes.
// One shift-and-add-3 stage is reused N times; optional two's-complement input.
module bin2bcd_seq #(
    parameter int N      = 8,
    parameter int SIGNED = 0,
    localparam int DIGITS = (N * 30103 + 99999) / 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   data_out,
    output logic                  sign_out,
    output logic                  busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [N-1:0]          bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  sign_pend;

    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_nxt;
    logic [N-1:0]          bin_nxt;
    logic [N-1:0]          mag;
    logic                  neg_in;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT);
    assign out_valid = (state == DONE);

    // The N-bit two's complement of -2^(N-1) is 2^(N-1) itself, which read
    // as unsigned is the exact magnitude, so no extra bit is needed.
    assign neg_in = (SIGNED != 0) && data_in[N-1];
    assign mag    = neg_in ? (~data_in + N'(1)) : data_in;

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bin       <= '0;
            bcd       <= '0;
            sign_pend <= 1'b0;
            data_out  <= '0;
            sign_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin       <= mag;
                        bcd       <= '0;
                        cnt       <= '0;
                        sign_pend <= neg_in;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin <= bin_nxt;
                    bcd <= bcd_nxt;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        data_out <= bcd_nxt;
                        sign_out <= sign_pend;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: unsigned N=8, signed N=8 and unsigned N=16
// instances sharing one clock and reset.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid_a, out_ready_a, in_ready_a, out_valid_a, sign_out_a, busy_a;
    logic [7:0]  data_in_a;
    logic [11:0] data_out_a;

    logic        in_valid_b, out_ready_b, in_ready_b, out_valid_b, sign_out_b, busy_b;
    logic [7:0]  data_in_b;
    logic [11:0] data_out_b;

    logic        in_valid_c, out_ready_c, in_ready_c, out_valid_c, sign_out_c, busy_c;
    logic [15:0] data_in_c;
    logic [19:0] data_out_c;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    bin2bcd_seq #(.N(8), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .data_in(data_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .data_out(data_out_a), .sign_out(sign_out_a), .busy(busy_a)
    );

    bin2bcd_seq #(.N(8), .SIGNED(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .data_in(data_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .data_out(data_out_b), .sign_out(sign_out_b), .busy(busy_b)
    );

    bin2bcd_seq #(.N(16), .SIGNED(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .data_in(data_in_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .data_out(data_out_c), .sign_out(sign_out_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic rdy(input int w);
        case (w)
            0:       return in_ready_a;
            1:       return in_ready_b;
            default: return in_ready_c;
        endcase
    endfunction

    function automatic logic ovalid(input int w);
        case (w)
            0:       return out_valid_a;
            1:       return out_valid_b;
            default: return out_valid_c;
        endcase
    endfunction

    function automatic logic [19:0] dout_of(input int w);
        case (w)
            0:       return {8'h00, data_out_a};
            1:       return {8'h00, data_out_b};
            default: return data_out_c;
        endcase
    endfunction

    function automatic logic sign_of(input int w);
        case (w)
            0:       return sign_out_a;
            1:       return sign_out_b;
            default: return sign_out_c;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] d);
        case (w)
            0:       begin in_valid_a = v; data_in_a = d[7:0]; end
            1:       begin in_valid_b = v; data_in_b = d[7:0]; end
            default: begin in_valid_c = v; data_in_c = d; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            0:       out_ready_a = r;
            1:       out_ready_b = r;
            default: out_ready_c = r;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one operand, waits for the result, holds it for 'stall' cycles, then consumes it.
    task automatic xfer(input int w, input logic [15:0] v, input int gap, input int stall,
                        output int lat, output logic [19:0] dout, output logic sgn);
        int k;
        repeat (gap) tick();
        drive(w, 1'b1, v);
        k = 0;
        while (!rdy(w) && k < 100) begin tick(); k++; end
        tick();
        drive(w, 1'b0, 16'h0000);
        lat = 0;
        while (!ovalid(w) && lat < 200) begin tick(); lat++; end
        dout = dout_of(w);
        sgn  = sign_of(w);
        repeat (stall) tick();
        set_ordy(w, 1'b1);
        tick();
        set_ordy(w, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic [19:0] dout;
        logic        sgn;
        logic        flag_a;
        logic        flag_b;

        rst_n = 1'b0;
        in_valid_a = 1'b0; out_ready_a = 1'b0; data_in_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; data_in_b = '0;
        in_valid_c = 1'b0; out_ready_c = 1'b0; data_in_c = '0;

        // Reset and idle state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(in_ready_a),  32'd1);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_busy",      32'(busy_a),      32'd0);
        check("rst_data_out",  32'(data_out_a),  32'd0);
        check("rst_sign_out",  32'(sign_out_a),  32'd0);
        check("rst_b_busy",    32'(busy_b),      32'd0);
        check("rst_c_ready",   32'(in_ready_c),  32'd1);

        // Unsigned N=8 directed values and latency
        xfer(0, 16'd255, 0, 0, lat, dout, sgn);
        check("u8_255_lat", 32'(lat), 32'd8);
        check("u8_255",     32'(dout), 32'h255);
        check("u8_255_sign", 32'(sgn), 32'd0);
        check("u8_hold_idle", 32'(data_out_a), 32'h255);
        xfer(0, 16'd0, 1, 2, lat, dout, sgn);
        check("u8_0_lat", 32'(lat), 32'd8);
        check("u8_0",     32'(dout), 32'h000);
        xfer(0, 16'd100, 0, 1, lat, dout, sgn);
        check("u8_100", 32'(dout), 32'h100);
        xfer(0, 16'd9, 2, 0, lat, dout, sgn);
        check("u8_9", 32'(dout), 32'h009);

        // Signed N=8
        xfer(1, 16'h0080, 0, 0, lat, dout, sgn);
        check("s8_m128_lat",  32'(lat),  32'd8);
        check("s8_m128_sign", 32'(sgn),  32'd1);
        check("s8_m128",      32'(dout), 32'h128);
        xfer(1, 16'h00FF, 0, 0, lat, dout, sgn);
        check("s8_m1_sign", 32'(sgn),  32'd1);
        check("s8_m1",      32'(dout), 32'h001);
        xfer(1, 16'h007F, 0, 0, lat, dout, sgn);
        check("s8_127_sign", 32'(sgn),  32'd0);
        check("s8_127",      32'(dout), 32'h127);
        xfer(1, 16'h0000, 0, 0, lat, dout, sgn);
        check("s8_0_sign", 32'(sgn),  32'd0);
        check("s8_0",      32'(dout), 32'h000);

        // N=16 backpressure: result held, second operand waits for the consume edge
        drive(2, 1'b1, 16'd65535);
        tick();
        drive(2, 1'b1, 16'd1234);
        lat = 0;
        while (!out_valid_c && lat < 200) begin tick(); lat++; end
        check("u16_lat",   32'(lat),        32'd16);
        check("u16_65535", 32'(data_out_c), 32'h65535);
        check("u16_sign",  32'(sign_out_c), 32'd0);
        flag_a = 1'b1;
        flag_b = 1'b0;
        repeat (20) begin
            tick();
            if (data_out_c !== 20'h65535 || out_valid_c !== 1'b1) flag_a = 1'b0;
            if (in_ready_c !== 1'b0) flag_b = 1'b1;
        end
        check("u16_stable",    32'(flag_a), 32'd1);
        check("u16_no_ready",  32'(flag_b), 32'd0);
        set_ordy(2, 1'b1);
        tick();
        set_ordy(2, 1'b0);
        check("u16_consumed",  32'(out_valid_c), 32'd0);
        check("u16_not_taken", 32'(busy_c),      32'd0);
        check("u16_ready",     32'(in_ready_c),  32'd1);
        tick();
        drive(2, 1'b0, 16'd0);
        check("u16_taken",      32'(busy_c),     32'd1);
        check("u16_hold_shift", 32'(data_out_c), 32'h65535);
        lat = 0;
        while (!out_valid_c && lat < 200) begin tick(); lat++; end
        check("u16_1234_lat", 32'(lat),        32'd16);
        check("u16_1234",     32'(data_out_c), 32'h01234);
        set_ordy(2, 1'b1);
        tick();
        set_ordy(2, 1'b0);

        // Exhaustive unsigned N=8 with random gaps and stalls
        for (int i = 0; i < 256; i++) begin
            xfer(0, 16'(i), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), lat, dout, sgn);
            check("exh_value", 32'(dout), 32'(ref_bcd(i)));
            check("exh_single", 32'(out_valid_a), 32'd0);
        end

        // Reset during SHIFT aborts the conversion
        drive(0, 1'b1, 16'd200);
        tick();
        drive(0, 1'b0, 16'd0);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_ovalid", 32'(out_valid_a), 32'd0);
        check("mid_rst_busy",   32'(busy_a),      32'd0);
        check("mid_rst_data",   32'(data_out_a),  32'd0);
        rst_n = 1'b1;
        flag_a = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid_a !== 1'b0) flag_a = 1'b1;
        end
        check("mid_rst_no_pulse", 32'(flag_a), 32'd0);
        xfer(0, 16'd37, 0, 0, lat, dout, sgn);
        check("post_rst_lat", 32'(lat),  32'd8);
        check("post_rst_37",  32'(dout), 32'h037);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
